// File: rtl/tiger_memaccess_if.sv
// Signal bundle for the Tiger memory-access stage: execute inputs, Avalon-MM data
// master and the registered writeback bundle.
interface tiger_memaccess_if;
    logic        ex_valid;
    logic        ex_load;
    logic        ex_store;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [31:0] ex_aluout;
    logic [31:0] ex_storedata;
    logic        ex_regwrite;
    logic [4:0]  ex_regnum;
    logic        stall;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_regnum;
    logic [31:0] wb_data;
    logic        misaligned;

    modport master (
        input  ex_valid, ex_load, ex_store, ex_size, ex_signed, ex_aluout,
               ex_storedata, ex_regwrite, ex_regnum,
               avm_readdata, avm_waitrequest, avm_readdatavalid,
        output stall, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
               wb_valid, wb_regwrite, wb_regnum, wb_data, misaligned
    );

    modport slave (
        output ex_valid, ex_load, ex_store, ex_size, ex_signed, ex_aluout,
               ex_storedata, ex_regwrite, ex_regnum,
               avm_readdata, avm_waitrequest, avm_readdatavalid,
        input  stall, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
               wb_valid, wb_regwrite, wb_regnum, wb_data, misaligned
    );
endinterface

// File: rtl/tiger_memaccess.sv
// Tiger MIPS memory-access stage: one instruction per cycle from execute, loads and
// stores over Avalon-MM through a small FSM, registered writeback bundle out.
module tiger_memaccess (
    input logic               clk,
    input logic               reset,
    tiger_memaccess_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  ld_lane;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        ld_regwrite;
    logic [4:0]  ld_regnum;
    logic        accept;
    logic        is_mem;
    logic        mis;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned_access(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    // stall is a registered decode of state, so accept only needs the state
    assign accept = bus.ex_valid && (state == IDLE);
    assign is_mem = bus.ex_load || bus.ex_store;
    assign mis    = is_mem && misaligned_access(bus.ex_size, bus.ex_aluout[1:0]);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !mis) begin
                    if (bus.ex_load)       state_next = RD_REQ;
                    else if (bus.ex_store) state_next = WR_REQ;
                end
            end
            RD_REQ:  if (!bus.avm_waitrequest)  state_next = RD_WAIT;
            RD_WAIT: if (bus.avm_readdatavalid) state_next = IDLE;
            WR_REQ:  if (!bus.avm_waitrequest)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            bus.stall          <= 1'b0;
            bus.avm_read       <= 1'b0;
            bus.avm_write      <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_writedata  <= '0;
            bus.avm_byteenable <= '0;
            bus.wb_valid       <= 1'b0;
            bus.wb_regwrite    <= 1'b0;
            bus.wb_regnum      <= '0;
            bus.wb_data        <= '0;
            bus.misaligned     <= 1'b0;
        end else begin
            state          <= state_next;
            bus.stall      <= (state_next != IDLE);
            bus.avm_read   <= (state_next == RD_REQ);
            bus.avm_write  <= (state_next == WR_REQ);
            bus.wb_valid   <= 1'b0;
            bus.misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem && !mis) begin
                            bus.avm_address    <= {bus.ex_aluout[31:2], 2'b00};
                            bus.avm_byteenable <= lane_mask(bus.ex_size, bus.ex_aluout[1:0]);
                            if (bus.ex_store)
                                bus.avm_writedata <= store_data(bus.ex_size, bus.ex_storedata);
                        end else begin
                            bus.wb_valid <= 1'b1;
                            bus.wb_data  <= bus.ex_aluout;
                            if (mis) begin
                                bus.wb_regwrite <= 1'b0;
                                bus.misaligned  <= 1'b1;
                            end else begin
                                bus.wb_regwrite <= bus.ex_regwrite;
                                bus.wb_regnum   <= bus.ex_regnum;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.avm_readdatavalid) begin
                        bus.wb_valid    <= 1'b1;
                        bus.wb_data     <= load_extract(bus.avm_readdata, ld_size, ld_lane, ld_signed);
                        bus.wb_regwrite <= ld_regwrite;
                        bus.wb_regnum   <= ld_regnum;
                    end
                end
                WR_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        bus.wb_valid    <= 1'b1;
                        bus.wb_regwrite <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load context captured at accept; only meaningful while a read is in flight
    always_ff @(posedge clk) begin
        if (accept && bus.ex_load && !mis) begin
            ld_lane     <= bus.ex_aluout[1:0];
            ld_size     <= bus.ex_size;
            ld_signed   <= bus.ex_signed;
            ld_regwrite <= bus.ex_regwrite;
            ld_regnum   <= bus.ex_regnum;
        end
    end
endmodule

// File: tb/tb_tiger_memaccess.sv
// Directed bench for tiger_memaccess: ALU pass-through, loads, stores, misaligned
// accesses, back-to-back stall behaviour and reset during a read.
module tb_tiger_memaccess;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    tiger_memaccess_if bus ();

    tiger_memaccess dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        bus.ex_valid          = 1'b0;
        bus.ex_load           = 1'b0;
        bus.ex_store          = 1'b0;
        bus.ex_size           = 2'b00;
        bus.ex_signed         = 1'b0;
        bus.ex_aluout         = 32'h0;
        bus.ex_storedata      = 32'h0;
        bus.ex_regwrite       = 1'b0;
        bus.ex_regnum         = 5'd0;
        bus.avm_readdata      = 32'h0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #2 reset = 1'b1;
        #2;
        total++;
        if ({bus.stall, bus.avm_read, bus.avm_write, bus.wb_valid, bus.wb_regwrite, bus.misaligned} !== 6'b0)
            $display("FAIL reset_ctrl: got %b required 000000",
                     {bus.stall, bus.avm_read, bus.avm_write, bus.wb_valid, bus.wb_regwrite, bus.misaligned});
        else passed++;
        total++;
        if ({bus.avm_address, bus.avm_writedata, bus.wb_data, bus.avm_byteenable, bus.wb_regnum} !== 105'b0)
            $display("FAIL reset_data: got addr %h wd %h wb %h be %b rn %0d required all zero",
                     bus.avm_address, bus.avm_writedata, bus.wb_data, bus.avm_byteenable, bus.wb_regnum);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        bus.ex_valid    = 1'b1;
        bus.ex_aluout   = 32'h1234_5678;
        bus.ex_regwrite = 1'b1;
        bus.ex_regnum   = 5'd9;
        total++;
        if (bus.stall !== 1'b0) $display("FAIL alu_stall_pre: got %b required 0", bus.stall);
        else passed++;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        total++;
        if ({bus.wb_valid, bus.wb_regwrite, bus.wb_regnum, bus.wb_data, bus.stall} !== {1'b1, 1'b1, 5'd9, 32'h1234_5678, 1'b0})
            $display("FAIL alu_wb: got v=%b rw=%b rn=%0d d=%h stall=%b required v=1 rw=1 rn=9 d=12345678 stall=0",
                     bus.wb_valid, bus.wb_regwrite, bus.wb_regnum, bus.wb_data, bus.stall);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.wb_valid, bus.wb_data} !== {1'b0, 32'h1234_5678})
            $display("FAIL alu_hold: got v=%b d=%h required v=0 d=12345678", bus.wb_valid, bus.wb_data);
        else passed++;
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic sgn, input logic [31:0] rdata, input int k,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        bus.ex_valid          = 1'b1;
        bus.ex_load           = 1'b1;
        bus.ex_store          = 1'b0;
        bus.ex_size           = size;
        bus.ex_signed         = sgn;
        bus.ex_aluout         = addr;
        bus.ex_regwrite       = 1'b1;
        bus.ex_regnum         = 5'd4;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        bus.ex_load  = 1'b0;
        total++;
        if ({bus.avm_read, bus.avm_write, bus.stall, bus.avm_address, bus.avm_byteenable} !== {1'b1, 1'b0, 1'b1, exp_addr, exp_be})
            $display("FAIL %s_req: got rd=%b wr=%b stall=%b addr=%h be=%b required rd=1 wr=0 stall=1 addr=%h be=%b",
                     name, bus.avm_read, bus.avm_write, bus.stall, bus.avm_address, bus.avm_byteenable, exp_addr, exp_be);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.avm_read, bus.stall, bus.wb_valid} !== 3'b010)
            $display("FAIL %s_wait: got rd=%b stall=%b v=%b required rd=0 stall=1 v=0",
                     name, bus.avm_read, bus.stall, bus.wb_valid);
        else passed++;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.stall, bus.wb_valid} !== 2'b10)
                $display("FAIL %s_latency: got stall=%b v=%b required stall=1 v=0", name, bus.stall, bus.wb_valid);
            else passed++;
        end
        bus.avm_readdata      = rdata;
        bus.avm_readdatavalid = 1'b1;
        @(posedge clk); #1;
        bus.avm_readdatavalid = 1'b0;
        total++;
        if ({bus.wb_valid, bus.wb_regwrite, bus.wb_regnum, bus.wb_data, bus.stall, bus.misaligned} !== {1'b1, 1'b1, 5'd4, exp_data, 1'b0, 1'b0})
            $display("FAIL %s_wb: got v=%b rw=%b rn=%0d d=%h stall=%b mis=%b required v=1 rw=1 rn=4 d=%h stall=0 mis=0",
                     name, bus.wb_valid, bus.wb_regwrite, bus.wb_regnum, bus.wb_data, bus.stall, bus.misaligned, exp_data);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({bus.wb_valid, bus.wb_data} !== {1'b0, exp_data})
            $display("FAIL %s_pulse: got v=%b d=%h required v=0 d=%h", name, bus.wb_valid, bus.wb_data, exp_data);
        else passed++;
    endtask

    task automatic test_store();
        int writes;
        bus.ex_valid        = 1'b1;
        bus.ex_store        = 1'b1;
        bus.ex_size         = 2'b01;
        bus.ex_aluout       = 32'h0000_0202;
        bus.ex_storedata    = 32'hAAAA_BEEF;
        bus.ex_regwrite     = 1'b1;
        bus.ex_regnum       = 5'd12;
        bus.avm_waitrequest = 1'b1;
        writes = 0;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        bus.ex_store = 1'b0;
        total++;
        if ({bus.avm_address, bus.avm_writedata, bus.avm_byteenable, bus.avm_read, bus.stall} !== {32'h200, 32'hBEEF_BEEF, 4'b1100, 1'b0, 1'b1})
            $display("FAIL sh_req: got addr=%h wd=%h be=%b rd=%b stall=%b required addr=00000200 wd=beefbeef be=1100 rd=0 stall=1",
                     bus.avm_address, bus.avm_writedata, bus.avm_byteenable, bus.avm_read, bus.stall);
        else passed++;
        if (bus.avm_write === 1'b1) writes++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.avm_write === 1'b1) writes++;
            total++;
            if ({bus.stall, bus.wb_valid} !== 2'b10)
                $display("FAIL sh_waitreq: got stall=%b v=%b required stall=1 v=0", bus.stall, bus.wb_valid);
            else passed++;
        end
        bus.avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        total++;
        if (writes !== 4) $display("FAIL sh_write_cycles: got %0d required 4", writes);
        else passed++;
        total++;
        if ({bus.wb_valid, bus.wb_regwrite, bus.stall, bus.avm_write} !== 4'b1000)
            $display("FAIL sh_wb: got v=%b rw=%b stall=%b wr=%b required v=1 rw=0 stall=0 wr=0",
                     bus.wb_valid, bus.wb_regwrite, bus.stall, bus.avm_write);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (bus.wb_valid !== 1'b0) $display("FAIL sh_pulse: got %b required 0", bus.wb_valid);
        else passed++;
    endtask

    task automatic test_misaligned();
        bus.ex_valid    = 1'b1;
        bus.ex_load     = 1'b1;
        bus.ex_size     = 2'b10;
        bus.ex_aluout   = 32'h0000_0301;
        bus.ex_regwrite = 1'b1;
        bus.ex_regnum   = 5'd6;
        @(posedge clk); #1;
        bus.ex_load   = 1'b0;
        bus.ex_store  = 1'b1;
        bus.ex_size   = 2'b01;
        bus.ex_aluout = 32'h0000_0203;
        total++;
        if ({bus.wb_valid, bus.misaligned, bus.wb_regwrite, bus.wb_data, bus.avm_read, bus.stall} !== {1'b1, 1'b1, 1'b0, 32'h301, 1'b0, 1'b0})
            $display("FAIL lw_mis: got v=%b mis=%b rw=%b d=%h rd=%b stall=%b required v=1 mis=1 rw=0 d=00000301 rd=0 stall=0",
                     bus.wb_valid, bus.misaligned, bus.wb_regwrite, bus.wb_data, bus.avm_read, bus.stall);
        else passed++;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        bus.ex_store = 1'b0;
        total++;
        if ({bus.wb_valid, bus.misaligned, bus.avm_write, bus.wb_data} !== {1'b1, 1'b1, 1'b0, 32'h203})
            $display("FAIL sh_mis: got v=%b mis=%b wr=%b d=%h required v=1 mis=1 wr=0 d=00000203",
                     bus.wb_valid, bus.misaligned, bus.avm_write, bus.wb_data);
        else passed++;
        bus.avm_readdatavalid = 1'b1;
        @(posedge clk); #1;
        bus.avm_readdatavalid = 1'b0;
        total++;
        if ({bus.wb_valid, bus.misaligned, bus.avm_read} !== 3'b000)
            $display("FAIL mis_idle: got v=%b mis=%b rd=%b required 000", bus.wb_valid, bus.misaligned, bus.avm_read);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        bus.ex_valid        = 1'b1;
        bus.ex_load         = 1'b1;
        bus.ex_size         = 2'b10;
        bus.ex_aluout       = 32'h0000_0500;
        bus.ex_regwrite     = 1'b1;
        bus.ex_regnum       = 5'd3;
        bus.avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        bus.ex_load   = 1'b0;
        bus.ex_aluout = 32'h0000_0055;
        bus.ex_regnum = 5'd7;
        total++;
        if ({bus.avm_read, bus.avm_byteenable, bus.stall} !== {1'b1, 4'b1111, 1'b1})
            $display("FAIL b2b_req: got rd=%b be=%b stall=%b required rd=1 be=1111 stall=1",
                     bus.avm_read, bus.avm_byteenable, bus.stall);
        else passed++;
        @(posedge clk); #1;
        bus.avm_readdata      = 32'hCAFE_F00D;
        bus.avm_readdatavalid = 1'b1;
        if (bus.wb_valid === 1'b1) pulses++;
        @(posedge clk); #1;
        bus.avm_readdatavalid = 1'b0;
        if (bus.wb_valid === 1'b1) pulses++;
        total++;
        if ({bus.wb_valid, bus.wb_regnum, bus.wb_data, bus.stall} !== {1'b1, 5'd3, 32'hCAFE_F00D, 1'b0})
            $display("FAIL b2b_load_wb: got v=%b rn=%0d d=%h stall=%b required v=1 rn=3 d=cafef00d stall=0",
                     bus.wb_valid, bus.wb_regnum, bus.wb_data, bus.stall);
        else passed++;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        if (bus.wb_valid === 1'b1) pulses++;
        total++;
        if ({bus.wb_valid, bus.wb_regnum, bus.wb_data} !== {1'b1, 5'd7, 32'h55})
            $display("FAIL b2b_alu_wb: got v=%b rn=%0d d=%h required v=1 rn=7 d=00000055",
                     bus.wb_valid, bus.wb_regnum, bus.wb_data);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.wb_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 2) $display("FAIL b2b_pulses: got %0d required 2", pulses);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bus.ex_valid        = 1'b1;
        bus.ex_load         = 1'b1;
        bus.ex_size         = 2'b00;
        bus.ex_aluout       = 32'h0000_0100;
        bus.ex_regwrite     = 1'b1;
        bus.ex_regnum       = 5'd2;
        bus.avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        total++;
        if (bus.stall !== 1'b1) $display("FAIL rst_mid_pre: got stall=%b required 1", bus.stall);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.stall, bus.avm_read, bus.wb_valid, bus.wb_data, bus.avm_address, bus.avm_byteenable} !== 71'b0)
            $display("FAIL rst_mid: got stall=%b rd=%b v=%b d=%h addr=%h be=%b required all zero",
                     bus.stall, bus.avm_read, bus.wb_valid, bus.wb_data, bus.avm_address, bus.avm_byteenable);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.avm_readdata      = 32'h0000_00AA;
        bus.avm_readdatavalid = 1'b1;
        @(posedge clk); #1;
        bus.avm_readdatavalid = 1'b0;
        total++;
        if ({bus.wb_valid, bus.stall, bus.wb_data} !== 34'b0)
            $display("FAIL rst_late_rdv: got v=%b stall=%b d=%h required v=0 stall=0 d=00000000",
                     bus.wb_valid, bus.stall, bus.wb_data);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_alu();
        test_load("lb",  32'h0000_0103, 2'b00, 1'b1, 32'h80FF_0000, 0, 32'h100, 4'b1000, 32'hFFFF_FF80);
        test_load("lbu", 32'h0000_0103, 2'b00, 1'b0, 32'h80FF_0000, 0, 32'h100, 4'b1000, 32'h0000_0080);
        test_load("lhu", 32'h0000_0402, 2'b01, 1'b0, 32'hBEEF_1234, 0, 32'h400, 4'b1100, 32'h0000_BEEF);
        test_load("lh",  32'h0000_0400, 2'b01, 1'b1, 32'h1234_9ABC, 2, 32'h400, 4'b0011, 32'hFFFF_9ABC);
        test_load("lbu1", 32'h0000_0601, 2'b00, 1'b1, 32'h0000_7F00, 1, 32'h600, 4'b0010, 32'h0000_007F);
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tiger_memaccess.md
# tiger_memaccess

Memory-access stage of the Tiger MIPS pipeline, between execute and writeback. Takes one instruction per cycle from execute, performs loads/stores on an Avalon-MM data master with a small FSM (stalling upstream while a transfer is outstanding), and presents the aligned, extended load result or pass-through ALU result as a registered writeback bundle. Byte order is little-endian: lane = addr[1:0].

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute presents an instruction
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store (never both with ex_load)
- ex_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ex_signed  in  1  sign-extend load result (byte/half only)
- ex_aluout  in  32  ALU result; memory address for load/store, else result
- ex_storedata  in  32  store source register value
- ex_regwrite  in  1  instruction writes a register
- ex_regnum  in  5  destination register
- stall  out  1  upstream must hold ex_* unchanged
- avm_address  out  32  word address ({addr[31:2],2'b00})
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  lane-replicated store data
- avm_byteenable  out  4  active lanes
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave not accepting request
- avm_readdatavalid  in  1  read data returned
- wb_valid  out  1  one-cycle pulse: bundle valid
- wb_regwrite  out  1  to writeback register-write enable
- wb_regnum  out  5  destination register
- wb_data  out  32  result to writeback
- misaligned  out  1  one-cycle pulse with wb_valid on misaligned access

## Operation
- Accept: ex_* consumed on an edge where ex_valid=1 and stall=0. stall = (state != IDLE), a registered-state decode.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE, accept, non-memory: wb_data<=ex_aluout, wb_regwrite<=ex_regwrite, wb_regnum<=ex_regnum, wb_valid<=1. Stay IDLE.
- IDLE, accept, misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus access; wb_valid<=1, wb_regwrite<=0, misaligned<=1, wb_data<=ex_aluout. Stay IDLE.
- IDLE, accept, aligned load: latch addr[1:0], size, signed, regnum, regwrite; -> RD_REQ.
- IDLE, accept, aligned store: latch address/writedata/byteenable; -> WR_REQ.
- RD_REQ: avm_read=1; on edge with avm_waitrequest=0 -> RD_WAIT.
- RD_WAIT: on edge with avm_readdatavalid=1: extract lane, extend, wb_data<=result, wb_regwrite<=latched regwrite, wb_valid<=1; -> IDLE.
- WR_REQ: avm_write=1; on edge with avm_waitrequest=0: wb_valid<=1, wb_regwrite<=0; -> IDLE.
- Byteenable: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111. Read requests also drive the same byteenable.
- Writedata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- Load extract: byte = readdata[8*addr[1:0]+:8]; half = readdata[16*addr[1]+:16]; extend by sign bit if ex_signed else zero; word unchanged.
- wb_valid, misaligned: high exactly one cycle per retired instruction; otherwise 0. wb_regnum/wb_data hold last value when wb_valid=0.
- avm_readdatavalid outside RD_WAIT is ignored. avm_read/avm_write never high together.

## Timing
- Reset (async): state IDLE; stall, avm_read, avm_write, wb_valid, wb_regwrite, misaligned = 0; avm_address, avm_writedata, wb_data = 0; avm_byteenable = 0; wb_regnum = 0. Reset mid-transfer aborts it; bus request drops immediately, no wb_valid.
- Non-memory/misaligned: accepted at edge N, wb_valid high cycle N..N+1 (1-cycle latency), no stall.
- Load: accept edge N; avm_read high from N; accepted edge N+1+w (w waitrequest cycles); data at edge N+2+w+k (k≥0 extra latency cycles); wb_valid the following cycle. Minimum 3 cycles, stall high 2.
- Store: accept edge N; avm_write high from N; wb_valid after edge N+1+w. Minimum 2 cycles, stall high 1.
- Bus outputs are registered; they change only on clock edges or reset.

## Test plan
- Non-memory ALU op aluout=0x1234_5678, regnum=9, regwrite=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_regnum=9, stall never high.
- LB signed addr=0x103, readdata=0x80FF_0000 returned 2 cycles after accept (waitrequest=0) -> byteenable=1000, avm_address=0x100, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr=0x202, storedata=0xAAAA_BEEF, waitrequest high 3 cycles -> avm_write held 4 cycles, writedata=0xBEEFBEEF, byteenable=1100, wb_regwrite=0, stall released when accepted.
- LW addr=0x301 -> no avm_read, misaligned=1 and wb_valid=1 one cycle, wb_regwrite=0.
- Back-to-back LW then ALU op: ALU op held by stall, retires exactly 1 cycle after load's wb_valid, one wb_valid pulse each.
- Reset asserted while in RD_WAIT -> outputs zero immediately; late avm_readdatavalid after reset produces no wb_valid.
